// File: rtl/uart_loader.sv
// Purpose: parses A5-framed UART load commands, writes 32-bit words to RAM, answers ACK/NAK, starts the core.
// Latency: one byte per 2 cycles from the RX FIFO; RAM write 1 cycle after the 4th data byte; response 2 cycles after CHK.
// Backpressure: reads only when rx_empty=0; holds in RESP while tx_full=1.
module uart_loader #(
    parameter int ADDR_W      = 13,
    parameter int TIMEOUT_CYC = 6000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_q,
    input  logic              rx_empty,
    output logic              rx_rdreq,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we,
    output logic [7:0]        tx_byte,
    output logic              tx_wrreq,
    input  logic              tx_full,
    output logic              core_run,
    output logic              busy,
    output logic              err
);

    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int HI_SH = ADDR_W - 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK, S_RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           pend;        // read issued last cycle; rx_q valid now
    logic [TW-1:0]  tcnt;
    logic           in_frame;
    logic           timeout_hit;
    logic           hdr_bad;
    logic [7:0]     csum;
    logic [7:0]     addr_hi;
    logic [7:0]     word_cnt;
    logic [1:0]     bsel;
    logic [23:0]    word_lo;
    logic           run_cmd;
    logic           resp_ack;
    logic           we_q;
    logic           wr_q;
    logic [15:0]    full_addr;

    assign in_frame    = (state != S_IDLE) && (state != S_RESP);
    assign timeout_hit = in_frame && !pend && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign hdr_bad     = ((rx_q >> HI_SH) != 8'd0);
    assign full_addr   = {addr_hi, rx_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: advance on each consumed byte, bail to RESP on timeout or bad header
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pend && rx_q == 8'hA5) state_nxt = S_ADDR_HI;
            S_ADDR_HI: if (timeout_hit) state_nxt = S_RESP;
                       else if (pend) state_nxt = hdr_bad ? S_RESP : S_ADDR_LO;
            S_ADDR_LO: if (timeout_hit) state_nxt = S_RESP;
                       else if (pend) state_nxt = S_LEN;
            S_LEN:     if (timeout_hit) state_nxt = S_RESP;
                       else if (pend) state_nxt = (rx_q == 8'd0) ? S_CHK : S_DATA;
            S_DATA:    if (timeout_hit) state_nxt = S_RESP;
                       else if (pend && bsel == 2'd3 && word_cnt == 8'd1) state_nxt = S_CHK;
            S_CHK:     if (timeout_hit) state_nxt = S_RESP;
                       else if (pend) state_nxt = S_RESP;
            S_RESP:    if (!tx_full) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs: fetch request, busy, and write strobes masked during reset
    always_comb begin
        busy     = (state != S_IDLE);
        rx_rdreq = !rst && (state != S_RESP) && !rx_empty && !pend && !timeout_hit;
        ram_we   = we_q && !rst;
        tx_wrreq = wr_q && !rst;
    end

    // Datapath: byte consumption, checksum, word assembly, address, timeout, response
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            tcnt     <= '0;
            csum     <= 8'd0;
            addr_hi  <= 8'd0;
            word_cnt <= 8'd0;
            bsel     <= 2'd0;
            word_lo  <= 24'd0;
            run_cmd  <= 1'b0;
            resp_ack <= 1'b0;
            we_q     <= 1'b0;
            wr_q     <= 1'b0;
            ram_addr <= '0;
            ram_data <= 32'd0;
            tx_byte  <= 8'd0;
            core_run <= 1'b0;
            err      <= 1'b0;
        end else begin
            pend <= rx_rdreq;
            we_q <= 1'b0;
            wr_q <= 1'b0;

            // post-increment after each RAM write; wraps naturally at 2^ADDR_W
            if (we_q) ram_addr <= ram_addr + 1'b1;

            if (!in_frame || pend || timeout_hit) tcnt <= '0;
            else                                  tcnt <= tcnt + 1'b1;

            if (timeout_hit) begin
                err      <= 1'b1;
                resp_ack <= 1'b0;
            end

            if (pend) begin
                case (state)
                    S_IDLE: if (rx_q == 8'hA5) begin
                        csum     <= 8'd0;
                        run_cmd  <= 1'b0;
                        resp_ack <= 1'b0;
                    end
                    S_ADDR_HI: begin
                        csum    <= csum ^ rx_q;
                        addr_hi <= rx_q;
                        if (hdr_bad) begin
                            err      <= 1'b1;
                            resp_ack <= 1'b0;
                        end
                    end
                    S_ADDR_LO: begin
                        csum     <= csum ^ rx_q;
                        ram_addr <= ADDR_W'(full_addr);
                    end
                    S_LEN: begin
                        csum     <= csum ^ rx_q;
                        word_cnt <= rx_q;
                        bsel     <= 2'd0;
                        run_cmd  <= (rx_q == 8'd0);
                    end
                    S_DATA: begin
                        csum <= csum ^ rx_q;
                        bsel <= bsel + 2'd1;
                        case (bsel)
                            2'd0: word_lo[7:0]   <= rx_q;
                            2'd1: word_lo[15:8]  <= rx_q;
                            2'd2: word_lo[23:16] <= rx_q;
                            default: begin
                                ram_data <= {rx_q, word_lo};
                                we_q     <= 1'b1;
                                word_cnt <= word_cnt - 8'd1;
                            end
                        endcase
                    end
                    S_CHK: begin
                        resp_ack <= (rx_q == csum);
                        if (rx_q != csum) err <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // issue the response; a clean run command starts the core with its ACK
            if (state == S_RESP && !tx_full) begin
                wr_q    <= 1'b1;
                tx_byte <= resp_ack ? 8'h06 : 8'h15;
                if (resp_ack && run_cmd) core_run <= 1'b1;
            end
        end
    end

endmodule
